// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan state encoding, the active-low hex segment table and the
// "everything dark" values for anodes and segments.
package sevenseg_pkg;

    // Scan phases within one digit slot.
    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Widest supported display; anode constants are sized for it and
    // sliced down by the user.
    localparam int MAX_DIGITS = 8;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex codes 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // All anodes off (active-low), sized for the widest display.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Larger of two integers, used to size the shared slot counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bundle of the datapath-facing inputs and display-pin outputs of the
// scan controller. The controller takes the slave view; whatever feeds
// it the value and observes the pins takes the master view.
interface sevenseg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic                  load;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic                  frame_tick;

    modport master (
        output value,
        output load,
        output digit_en,
        input  an,
        input  seg,
        input  frame_tick
    );

    modport slave (
        input  value,
        input  load,
        input  digit_en,
        output an,
        output seg,
        output frame_tick
    );
endinterface

// File: rtl/sevenseg_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Straight table lookup; the table already holds active-low patterns.
    always_comb begin
        o_seg = SEG_TABLE[i_nib];
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment
// display. A shadow register holds the packed hex value; each digit gets
// a slot of BLANK_CYC dark cycles followed by ON_CYC lit cycles. The
// digit's nibble and enable are frozen into a slot register at the
// BLANK->ON edge so mid-slot loads or enable changes never glitch the
// lit digit. an/seg are registered from the current state (one cycle
// behind it); frame_tick is registered from the next state so that it
// lands exactly on the final ON cycle of the last digit.
//
// Build option: define SEVSEG_LZ_SUPPRESS_EN to blank leading-zero
// digits (digit 0 is never suppressed).
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sevenseg_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = max2(ON_CYC, BLANK_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    // State and datapath registers
    scan_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [3:0]            r_slot_nib;
    logic                  r_slot_en;
    logic [N_DIGITS-1:0]   r_an;
    logic [6:0]            r_seg;
    logic                  r_frame_tick;

    // Next-state and combinational helpers
    scan_state_t           w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_capture;
    logic [3:0]            w_nibs [N_DIGITS];
    logic [N_DIGITS-1:0]   w_upper_zero;
    logic [N_DIGITS-1:0]   w_an_lit;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_en;
    logic                  w_slot_en_next;
    logic [6:0]            w_dec_seg;
    logic [N_DIGITS-1:0]   w_an_next;
    logic [6:0]            w_seg_next;
    logic                  w_frame_tick_next;

    // Per-digit views of the shadow value: the nibble itself, whether it
    // and every more significant nibble are zero, and the one-cold anode
    // pattern that lights just this digit.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign w_nibs[gi]       = r_shadow[4*gi +: 4];
            assign w_upper_zero[gi] = ~|r_shadow[4*N_DIGITS-1 : 4*gi];
            assign w_an_lit[gi]     = (r_idx != IDX_W'(gi));
        end
    endgenerate

    assign w_cur_nib = w_nibs[r_idx];
    assign w_cur_en  = bus.digit_en[r_idx];

`ifdef SEVSEG_LZ_SUPPRESS_EN
    // A digit above position 0 whose nibble and all higher nibbles are
    // zero is a leading zero and stays dark.
    assign w_slot_en_next = w_cur_en & ~((r_idx != '0) & w_upper_zero[r_idx]);
`else
    // Every enabled digit is shown, leading zeros included; the zero
    // flags are not needed in this build.
    assign w_slot_en_next = w_cur_en;
    logic w_unused_upper_zero;
    assign w_unused_upper_zero = ^w_upper_zero;
`endif

    // Scan state register: phase, slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic: count through BLANK then ON, advancing the digit
    // index (with wrap) at the end of each ON phase.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_next = ON;
                    w_cnt_next   = '0;
                    w_capture    = 1'b1;
                end
            end
            ON: begin
                if (r_cnt == ON_LAST) begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_next = BLANK;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Shadow register takes the datapath value only when load is pulsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (bus.load) begin
            r_shadow <= bus.value;
        end
    end

    // Slot register: freeze this digit's nibble and enable at BLANK->ON,
    // reading the shadow as it stood before any same-edge load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_nib <= '0;
            r_slot_en  <= 1'b0;
        end else if (w_capture) begin
            r_slot_nib <= w_cur_nib;
            r_slot_en  <= w_slot_en_next;
        end
    end

    sevenseg_hex_decode u_decode (
        .i_nib (r_slot_nib),
        .o_seg (w_dec_seg)
    );

    // Pin values for the current phase, plus the end-of-frame marker
    // looked ahead one cycle so the registered pulse is on time.
    always_comb begin
        w_an_next  = AN_OFF[N_DIGITS-1:0];
        w_seg_next = SEG_OFF;
        if (r_state == ON && r_slot_en) begin
            w_an_next  = w_an_lit;
            w_seg_next = w_dec_seg;
        end
        w_frame_tick_next = (w_state_next == ON) && (w_cnt_next == ON_LAST) &&
                            (w_idx_next == IDX_LAST);
    end

    // Registered display pins and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= AN_OFF[N_DIGITS-1:0];
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_frame_tick <= w_frame_tick_next;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. One hex-to-segment decoder is shared across N_DIGITS digits. The block latches a packed hex value, steps a digit index through fixed blank/on time slots, and drives the anode enables and segment lines. It sits between the lab datapath's result register and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned; range 2..8.
ON_CYC, 50000, clock cycles a digit is lit per slot; must be ≥1.
BLANK_CYC, 500, anti-ghosting cycles per slot with all anodes off, before the digit lights; must be ≥1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*N_DIGITS  packed hex digits; nibble k [4k+3:4k] shown on digit k; digit 0 is least significant
load  in  1  capture value into the shadow register on this clock edge
digit_en  in  N_DIGITS  per-digit enable; 0 blanks that digit for its whole slot
an  out  N_DIGITS  anode enables, active-low, registered
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
frame_tick  out  1  one-cycle pulse on the last cycle of the last digit's ON phase

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - an = all 1
  - seg = 7'h7F
  - frame_tick = 0
  - shadow = 0
  - digit index = 0
  - state = BLANK
  - slot counter = 0
- Shadow register:
  - Updated on the edge where load=1.
  - value is ignored otherwise.
- FSM states: BLANK and ON.
- BLANK:
  - an = all 1, seg = 7'h7F.
  - Counter runs 0..BLANK_CYC-1.
  - At terminal count, go to ON. On that edge, capture the current digit's nibble from shadow and its digit_en bit into a slot register.
- ON:
  - If the captured enable is 1: an has only bit [index] = 0, and seg = decode(captured nibble).
  - If the captured enable is 0: an = all 1, seg = 7'h7F.
  - Counter runs 0..ON_CYC-1. At terminal count, go to BLANK and advance the index.
  - The index wraps from N_DIGITS-1 to 0.
- Slot length is BLANK_CYC+ON_CYC cycles. Frame length is N_DIGITS times that.
- Outputs are registered. an and seg reflect the state and index one cycle after each transition edge.
- frame_tick is asserted for exactly one cycle, on the final ON cycle of digit N_DIGITS-1.
- Simultaneous events:
  - A load in the same cycle as BLANK→ON: the slot captures the OLD shadow contents.
  - A load at any point in a slot does not change the lit digit until the next slot.
  - Changes to digit_en mid-slot are likewise ignored until the next BLANK→ON capture.
- Decode table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, 7-bit)
- Reset mid-scan forces the reset values immediately (asynchronous). The scan restarts at digit 0 in BLANK with the counter at 0.
- Counter width: $clog2(max(ON_CYC, BLANK_CYC)).
  - Terminal compares use full width.
  - There is no overflow path.

Optional Feature:
SEVSEG_LZ_SUPPRESS_EN
- Defined (leading-zero suppression):
  - At BLANK→ON capture, digit k is treated as disabled if k > 0 and every shadow nibble from k up to N_DIGITS-1 is 0.
  - Digit 0 is always shown when its digit_en bit is 1, so a value of 0 displays "0".
  - Suppression is ANDed with digit_en.
- Undefined: all enabled digits show their nibble, including leading zeros.

Decomposition:
- Package sevenseg_pkg contains:
  - Enum scan_state_t {BLANK, ON}.
  - The 16-entry active-low segment table as a localparam array.
  - Constants SEG_OFF = 7'h7F and AN_OFF (all 1).
- One sub-module, sevenseg_hex_decode:
  - Purely combinational: 4-bit nibble in, 7-bit active-low segments out.
  - Instantiated once and fed by the captured slot nibble.

Test Plan:
Common setup: N_DIGITS=4, BLANK_CYC=2, ON_CYC=4; slot = 6 cycles, frame = 24 cycles.
1. Reset, then load 16'h1234 and run 1 frame:
   - Digit 0 ON: an=4'b1110, seg=7'h19.
   - Digit 1 ON: an=4'b1101, seg=7'h30.
   - Digit 2 ON: an=4'b1011, seg=7'h24.
   - Digit 3 ON: an=4'b0111, seg=7'h79.
   - In every BLANK phase: an=4'hF, seg=7'h7F.
   - frame_tick is 1 exactly once per 24 cycles.
2. Load 16'hABCD exactly on the digit-1 BLANK→ON edge:
   - Digit 1 shows 3 (seg=7'h30) from the old value.
   - Digit 2 then shows B (seg=7'h03).
3. digit_en=4'b1010 with value 16'hFFFF:
   - Digits 0 and 2 keep an=4'hF and seg=7'h7F during ON.
   - Digits 1 and 3 show seg=7'h0E.
4. Assert rst_n=0 mid ON of digit 2:
   - an=4'hF and seg=7'h7F immediately.
   - After release, scanning restarts at digit 0 after 2 BLANK cycles, and the shadow reads 0 (digit 0 shows seg=7'h40).
5. With SEVSEG_LZ_SUPPRESS_EN, value 16'h0050, digit_en=4'hF:
   - Digits 3 and 2 stay blank.
   - Digit 1 shows seg=7'h12; digit 0 shows seg=7'h40.
   - With value 16'h0000, only digit 0 shows 7'h40.
6. Sweep all 16 nibbles through digit 0 (one load per frame): seg matches the decode table for every code 0..F.
